// File: rtl/spawn_scheduler_pkg.sv
// Shared game constants and the fill-FSM state type for the spawn scheduler.
package spawn_scheduler_pkg;

  localparam int POS_W            = 10;
  localparam int X_LIMIT_DEF      = 640;
  localparam int SPAWN_PERIOD_DEF = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SETTLE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/spawn_scheduler_if.sv
// Generator request path and spawn handshake. Handshake: a spawn transfers on
// the rising edge where spawn_valid && spawn_ready; spawn_x is stable while valid.
interface spawn_scheduler_if import spawn_scheduler_pkg::*; ();
  logic             rand_new;
  logic [POS_W-1:0] rand_data;
  logic             spawn_valid;
  logic [POS_W-1:0] spawn_x;
  logic             spawn_ready;

  modport master (
    output rand_new, spawn_valid, spawn_x,
    input  rand_data, spawn_ready
  );

  modport slave (
    input  rand_new, spawn_valid, spawn_x,
    output rand_data, spawn_ready
  );
endinterface

// File: rtl/spawn_scheduler_fifo.sv
// Small synchronous FIFO; one extra pointer bit keeps full and empty distinct.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spawn_scheduler.sv
// Pulls range-checked positions from the generator into a FIFO and releases
// one spawn position per spawn period over a valid/ready handshake.
module spawn_scheduler import spawn_scheduler_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int X_LIMIT      = X_LIMIT_DEF,
  parameter int SPAWN_PERIOD = SPAWN_PERIOD_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_tick,
  spawn_scheduler_if.master      bus,
  output logic [$clog2(DEPTH):0] fill,
  output logic [7:0]             rejects,
  output fill_state_e            dbg_state_o,
  output logic                   dbg_due_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  fill_state_e      state_q;
  logic             rand_new_q, valid_q, due_q;
  logic [POS_W-1:0] x_q;
  logic [PW-1:0]    pcnt_q;
  logic [7:0]       rejects_q;

  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [POS_W-1:0] fifo_head;
  logic             sample_ok, push, pop, wrap, room_after;

  always_comb begin
    sample_ok  = (int'(bus.rand_data) < X_LIMIT);
    push       = (state_q == ST_REQ) && sample_ok && !fifo_full;
    // A release may reuse the output register on the same edge it is accepted.
    pop        = due_q && !fifo_empty && (!valid_q || bus.spawn_ready);
    wrap       = enable && frame_tick && (pcnt_q == PW'(SPAWN_PERIOD - 1));
    room_after = (fifo_count - CW'(pop)) < CW'(DEPTH);
  end

  sync_fifo #(.WIDTH(POS_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.rand_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rand_new_q <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      pcnt_q     <= '0;
      due_q      <= 1'b0;
      rejects_q  <= '0;
    end else begin
      rand_new_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && !fifo_full) begin
            state_q    <= ST_REQ;
            rand_new_q <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_SETTLE;
          if (!sample_ok && rejects_q != 8'hFF) rejects_q <= rejects_q + 8'd1;
        end
        ST_SETTLE: begin
          if (enable && room_after) begin
            state_q    <= ST_REQ;
            rand_new_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (enable && frame_tick) pcnt_q <= wrap ? '0 : pcnt_q + 1'b1;
      // Only one spawn can be pending; wraps while pending are absorbed.
      due_q <= wrap || (due_q && !pop);

      if (pop) begin
        valid_q <= 1'b1;
        x_q     <= fifo_head;
      end else if (bus.spawn_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rand_new    = rand_new_q;
  assign bus.spawn_valid = valid_q;
  assign bus.spawn_x     = x_q;
  assign fill            = fifo_count;
  assign rejects         = rejects_q;
  assign dbg_state_o     = state_q;
  assign dbg_due_o       = due_q;
endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: fill sequencing, range rejects, release
// timing, backpressure, empty-FIFO pending spawn, and mid-operation reset.
module tb_spawn_scheduler;
  import spawn_scheduler_pkg::*;

  logic        clock = 1'b0;
  logic        reset, enable, frame_tick;
  logic [2:0]  fill;
  logic [7:0]  rejects;
  fill_state_e dbg_state;
  logic        dbg_due;

  spawn_scheduler_if bus();

  spawn_scheduler #(.DEPTH(4), .X_LIMIT(640), .SPAWN_PERIOD(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .bus         (bus),
    .fill        (fill),
    .rejects     (rejects),
    .dbg_state_o (dbg_state),
    .dbg_due_o   (dbg_due)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] gen_q[$];

  typedef struct {
    logic       rand_new;
    logic [2:0] fill;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: model pushes/handshakes seen before the edge, then answer the generator strobe.
  task automatic tick();
    logic       hs;
    logic [9:0] hx;
    logic [9:0] e;
    hs = !reset && bus.spawn_valid && bus.spawn_ready;
    hx = bus.spawn_x;
    if (!reset && bus.rand_new && bus.rand_data < 10'd640 && fill < 3'd4)
      exp_q.push_back(bus.rand_data);
    @(posedge clock);
    #1;
    if (reset) exp_q.delete();
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_spawn", 32'(hx), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_spawn_x", 32'(hx), 32'(e));
      end
    end
    if (bus.rand_new) begin
      if (gen_q.size() > 0) bus.rand_data = gen_q.pop_front();
      else                  bus.rand_data = 10'd1023;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    frame_tick = 1'b0;
    bus.spawn_ready = 1'b0;
    bus.rand_data = '0;
    gen_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    // cycle-indexed expectations after reset with enable high
    vecs[0]  = '{1'b0, 3'd0}; vecs[1]  = '{1'b1, 3'd0};
    vecs[2]  = '{1'b0, 3'd1}; vecs[3]  = '{1'b1, 3'd1};
    vecs[4]  = '{1'b0, 3'd2}; vecs[5]  = '{1'b1, 3'd2};
    vecs[6]  = '{1'b0, 3'd3}; vecs[7]  = '{1'b1, 3'd3};
    vecs[8]  = '{1'b0, 3'd4}; vecs[9]  = '{1'b0, 3'd4};
    vecs[10] = '{1'b0, 3'd4}; vecs[11] = '{1'b0, 3'd4};

    // Reset state and fill sequencing
    do_reset();
    chk("rst_valid", 32'(bus.spawn_valid), 0);
    chk("rst_x", 32'(bus.spawn_x), 0);
    chk("rst_rejects", 32'(rejects), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_due", 32'(dbg_due), 0);
    gen_q = '{10'd100, 10'd200, 10'd300, 10'd400};
    for (int i = 0; i < 12; i++) begin
      if (i == 0) enable = 1'b1;
      else tick();
      chk($sformatf("t1_rand_new_c%0d", i), 32'(bus.rand_new), 32'(vecs[i].rand_new));
      chk($sformatf("t1_fill_c%0d", i), 32'(fill), 32'(vecs[i].fill));
    end
    chk("t1_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Release after third frame tick with a full FIFO
    bus.spawn_ready = 1'b1;
    gen_q.push_back(10'd500);
    frame_pulse();
    frame_pulse();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("t3_due_set", 32'(dbg_due), 1);
    chk("t3_valid_pre", 32'(bus.spawn_valid), 0);
    tick();
    chk("t3_valid", 32'(bus.spawn_valid), 1);
    chk("t3_x", 32'(bus.spawn_x), 100);
    chk("t3_fill_pop", 32'(fill), 3);
    chk("t3_due_clr", 32'(dbg_due), 0);
    tick();
    chk("t3_valid_drop", 32'(bus.spawn_valid), 0);
    chk("t3_refill_req", 32'(bus.rand_new), 1);
    tick();
    chk("t3_refill_fill", 32'(fill), 4);

    // Backpressure: offered spawn holds through a second wrap
    bus.spawn_ready = 1'b0;
    frame_pulse();
    frame_pulse();
    frame_pulse();
    chk("t4_valid", 32'(bus.spawn_valid), 1);
    chk("t4_x", 32'(bus.spawn_x), 200);
    for (int i = 0; i < 10; i++) begin
      frame_tick = (i % 3 == 0);
      tick();
      frame_tick = 1'b0;
      chk($sformatf("t4_hold_valid_%0d", i), 32'(bus.spawn_valid), 1);
      chk($sformatf("t4_hold_x_%0d", i), 32'(bus.spawn_x), 200);
    end
    chk("t4_due_pending", 32'(dbg_due), 1);
    bus.spawn_ready = 1'b1;
    tick();
    chk("t4_reload_valid", 32'(bus.spawn_valid), 1);
    chk("t4_reload_x", 32'(bus.spawn_x), 300);
    chk("t4_reload_due", 32'(dbg_due), 0);
    tick();
    chk("t4_final_drop", 32'(bus.spawn_valid), 0);

    // Range check and FIFO order
    do_reset();
    gen_q = '{10'd700, 10'd639, 10'd640, 10'd5};
    enable = 1'b1;
    repeat (8) tick();
    enable = 1'b0;
    chk("t2_fill", 32'(fill), 2);
    chk("t2_rejects", 32'(rejects), 2);
    tick();
    tick();
    chk("t2_idle", 32'(dbg_state), 32'(ST_IDLE));
    bus.spawn_ready = 1'b1;
    enable = 1'b1;
    repeat (3) frame_pulse();
    chk("t2_first_valid", 32'(bus.spawn_valid), 1);
    chk("t2_first_x", 32'(bus.spawn_x), 639);
    repeat (3) frame_pulse();
    chk("t2_second_valid", 32'(bus.spawn_valid), 1);
    chk("t2_second_x", 32'(bus.spawn_x), 5);

    // Wrap with an empty FIFO keeps the spawn pending
    do_reset();
    enable = 1'b1;
    repeat (3) frame_pulse();
    chk("t5_due", 32'(dbg_due), 1);
    chk("t5_fill", 32'(fill), 0);
    enable = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_due_hold_%0d", i), 32'(dbg_due), 1);
      chk($sformatf("t5_valid_low_%0d", i), 32'(bus.spawn_valid), 0);
    end
    chk("t5_idle", 32'(dbg_state), 32'(ST_IDLE));
    gen_q.push_back(10'd42);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (fill == 3'd1) found = 1'b1;
    end
    chk("t5_push_seen", 32'(found), 1);
    chk("t5_valid_at_push", 32'(bus.spawn_valid), 0);
    tick();
    chk("t5_valid", 32'(bus.spawn_valid), 1);
    chk("t5_x", 32'(bus.spawn_x), 42);
    chk("t5_fill_after", 32'(fill), 0);

    // Reset mid-operation
    do_reset();
    gen_q = '{10'd1, 10'd2, 10'd3, 10'd4};
    enable = 1'b1;
    repeat (10) tick();
    chk("t6_fill_full", 32'(fill), 4);
    repeat (3) frame_pulse();
    chk("t6_valid", 32'(bus.spawn_valid), 1);
    chk("t6_x", 32'(bus.spawn_x), 1);
    chk("t6_fill3", 32'(fill), 3);
    tick();
    tick();
    chk("t6_rejects", 32'(rejects), 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_fill", 32'(fill), 0);
    chk("t6_rst_valid", 32'(bus.spawn_valid), 0);
    chk("t6_rst_rejects", 32'(rejects), 0);
    chk("t6_rst_x", 32'(bus.spawn_x), 0);
    reset = 1'b0;
    enable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
